// File: rtl/rob.sv
// rob: reorder buffer between issue and the register file.
//   Issue allocates entries in program order at the tail, the CDB marks
//   entries complete out of order, and the head retires in order, one per
//   cycle, to the register file. It also serves two rename lookups.
//
// Optional feature: define ROB_CDB_BYPASS_EN so that lookups also see the
// result on the CDB in the same cycle; by default lookups see stored state only.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rdy                    global enable; low holds all state, drops COM_valid
//   flush                  misprediction flush, empties the buffer
//   IS_valid, IS_rd        allocation request and its destination register
//   IS_name, IS_full       index the next allocation receives, buffer full
//   CDB_valid/name/val     result broadcast
//   REG_ord1/2             entries queried by the register file
//   REG_rdy1/2, REG_val1/2 queried entry ready flag and value
//   COM_valid/rd/val/name  registered commit to the register file
module rob #(
  parameter int unsigned ROB_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              IS_valid,
  input  logic [4:0]        IS_rd,
  output logic [ROB_AW-1:0] IS_name,
  output logic              IS_full,
  input  logic              CDB_valid,
  input  logic [ROB_AW-1:0] CDB_name,
  input  logic [31:0]       CDB_val,
  input  logic [ROB_AW-1:0] REG_ord1,
  input  logic [ROB_AW-1:0] REG_ord2,
  output logic              REG_rdy1,
  output logic              REG_rdy2,
  output logic [31:0]       REG_val1,
  output logic [31:0]       REG_val2,
  output logic              COM_valid,
  output logic [4:0]        COM_rd,
  output logic [31:0]       COM_val,
  output logic [ROB_AW-1:0] COM_name
);

  localparam int unsigned DEPTH = 1 << ROB_AW;
  localparam int unsigned CW    = ROB_AW + 1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  ready;
  logic [4:0]        rd_q  [DEPTH];
  logic [31:0]       val_q [DEPTH];
  logic [ROB_AW-1:0] head;
  logic [ROB_AW-1:0] tail;
  logic [CW-1:0]     count;

  logic commit_c;
  logic alloc_c;
  logic cdb_hit_c;

  assign IS_full = (count == CW'(DEPTH));
  assign IS_name = tail;

  // Commit decision uses only registered state, so a head completed this
  // cycle retires on the following edge.
  assign commit_c  = rdy && !flush && (count != '0) && busy[head] && ready[head];
  // A full buffer still accepts an allocation when the head retires in the
  // same cycle: the freed head slot is the old tail.
  assign alloc_c   = rdy && !flush && IS_valid && (!IS_full || commit_c);
  assign cdb_hit_c = rdy && !flush && CDB_valid && busy[CDB_name];

  // Rename lookups
  always_comb begin
    REG_rdy1 = busy[REG_ord1] && ready[REG_ord1];
    REG_val1 = REG_rdy1 ? val_q[REG_ord1] : '0;
    REG_rdy2 = busy[REG_ord2] && ready[REG_ord2];
    REG_val2 = REG_rdy2 ? val_q[REG_ord2] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (CDB_valid && (CDB_name == REG_ord1) && busy[REG_ord1]) begin
      REG_rdy1 = 1'b1;
      REG_val1 = CDB_val;
    end
    if (CDB_valid && (CDB_name == REG_ord2) && busy[REG_ord2]) begin
      REG_rdy2 = 1'b1;
      REG_val2 = CDB_val;
    end
`endif
  end

  // Pointers, entry flags and commit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      ready     <= '0;
      COM_valid <= 1'b0;
      COM_rd    <= '0;
      COM_val   <= '0;
      COM_name  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      ready     <= '0;
      COM_valid <= 1'b0;
    end else if (!rdy) begin
      COM_valid <= 1'b0;
    end else begin
      COM_valid <= commit_c;
      if (commit_c) begin
        COM_rd     <= rd_q[head];
        COM_val    <= val_q[head];
        COM_name   <= head;
        busy[head] <= 1'b0;
        head       <= head + ROB_AW'(1);
      end
      if (cdb_hit_c) begin
        ready[CDB_name] <= 1'b1;
      end
      // Last so that a full-buffer allocation into the retiring slot wins
      if (alloc_c) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + ROB_AW'(1);
      end
      count <= count + CW'(alloc_c) - CW'(commit_c);
    end
  end

  // Entry payload; only meaningful while the entry is busy, so no reset
  always_ff @(posedge clk) begin
    if (alloc_c) begin
      rd_q[tail] <= IS_rd;
    end
    if (cdb_hit_c) begin
      val_q[CDB_name] <= CDB_val;
    end
  end

endmodule

// File: tb/tb_rob.sv
// tb_rob: self-checking bench for rob. Directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_rob;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic          IS_valid;
  logic [4:0]    IS_rd;
  logic [AW-1:0] IS_name;
  logic          IS_full;
  logic          CDB_valid;
  logic [AW-1:0] CDB_name;
  logic [31:0]   CDB_val;
  logic [AW-1:0] REG_ord1;
  logic [AW-1:0] REG_ord2;
  logic          REG_rdy1;
  logic          REG_rdy2;
  logic [31:0]   REG_val1;
  logic [31:0]   REG_val2;
  logic          COM_valid;
  logic [4:0]    COM_rd;
  logic [31:0]   COM_val;
  logic [AW-1:0] COM_name;

  int checks = 0;
  int errors = 0;

  rob #(.ROB_AW(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .IS_valid(IS_valid), .IS_rd(IS_rd), .IS_name(IS_name), .IS_full(IS_full),
    .CDB_valid(CDB_valid), .CDB_name(CDB_name), .CDB_val(CDB_val),
    .REG_ord1(REG_ord1), .REG_ord2(REG_ord2),
    .REG_rdy1(REG_rdy1), .REG_rdy2(REG_rdy2),
    .REG_val1(REG_val1), .REG_val2(REG_val2),
    .COM_valid(COM_valid), .COM_rd(COM_rd), .COM_val(COM_val), .COM_name(COM_name)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_valid;
    logic [4:0]  is_rd;
    bit          cdb_valid;
    logic [3:0]  cdb_name;
    logic [31:0] cdb_val;
    bit          en;
    logic [3:0]  exp_name;
    bit          exp_cv;
    logic [3:0]  exp_cname;
    logic [4:0]  exp_crd;
    logic [31:0] exp_cval;
  } vec_t;

  typedef struct {
    logic [3:0]  name;
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] val;
  } ment_t;

  vec_t  vecs [14];
  ment_t mq [$];
  int    mtail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    IS_valid = 1'b0; IS_rd = '0;
    CDB_valid = 1'b0; CDB_name = '0; CDB_val = '0;
    REG_ord1 = '0; REG_ord2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      IS_valid = 1'b1;
      IS_rd = 5'(i + 1);
      tick();
    end
    IS_valid = 1'b0;
  endtask

  // Model lookup: an in-flight entry with that name, ready or (bypass) on the CDB now
  function automatic void mlook(input logic [3:0] ord, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (mq[i]) begin
      if (mq[i].name == ord) begin
        if (mq[i].ready) begin
          r = 1'b1;
          v = mq[i].val;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (CDB_valid && CDB_name == ord) begin
          r = 1'b1;
          v = CDB_val;
        end
`endif
      end
    end
  endfunction

  initial begin
    logic        er;
    logic [31:0] ev;
    bit          exp_cv;
    logic [3:0]  exp_cname;
    logic [4:0]  exp_crd;
    logic [31:0] exp_cval;
    bit          commit;
    bit          alloc;

    // In-order commit of out-of-order completion, then rdy stall
    vecs[0]  = '{1, 5'd1, 0, 4'd0, 32'h0,  1, 4'd0, 0, 4'd0, 5'd0, 32'h0};
    vecs[1]  = '{1, 5'd2, 0, 4'd0, 32'h0,  1, 4'd1, 0, 4'd0, 5'd0, 32'h0};
    vecs[2]  = '{1, 5'd3, 0, 4'd0, 32'h0,  1, 4'd2, 0, 4'd0, 5'd0, 32'h0};
    vecs[3]  = '{0, 5'd0, 1, 4'd2, 32'hC,  1, 4'd3, 0, 4'd0, 5'd0, 32'h0};
    vecs[4]  = '{0, 5'd0, 1, 4'd0, 32'hA,  1, 4'd3, 0, 4'd0, 5'd0, 32'h0};
    vecs[5]  = '{0, 5'd0, 1, 4'd1, 32'hB,  1, 4'd3, 1, 4'd0, 5'd1, 32'hA};
    vecs[6]  = '{0, 5'd0, 0, 4'd0, 32'h0,  1, 4'd3, 1, 4'd1, 5'd2, 32'hB};
    vecs[7]  = '{0, 5'd0, 0, 4'd0, 32'h0,  1, 4'd3, 1, 4'd2, 5'd3, 32'hC};
    vecs[8]  = '{1, 5'd4, 0, 4'd0, 32'h0,  1, 4'd3, 0, 4'd0, 5'd0, 32'h0};
    vecs[9]  = '{0, 5'd0, 1, 4'd3, 32'h33, 1, 4'd4, 0, 4'd0, 5'd0, 32'h0};
    vecs[10] = '{0, 5'd0, 0, 4'd0, 32'h0,  0, 4'd4, 0, 4'd0, 5'd0, 32'h0};
    vecs[11] = '{0, 5'd0, 0, 4'd0, 32'h0,  0, 4'd4, 0, 4'd0, 5'd0, 32'h0};
    vecs[12] = '{0, 5'd0, 0, 4'd0, 32'h0,  0, 4'd4, 0, 4'd0, 5'd0, 32'h0};
    vecs[13] = '{0, 5'd0, 0, 4'd0, 32'h0,  1, 4'd4, 1, 4'd3, 5'd4, 32'h33};

    do_reset();
    check("reset IS_full", 32'(IS_full), 32'd0);
    check("reset IS_name", 32'(IS_name), 32'd0);
    check("reset COM_valid", 32'(COM_valid), 32'd0);
    check("reset COM_name", 32'(COM_name), 32'd0);

    foreach (vecs[k]) begin
      IS_valid = vecs[k].is_valid; IS_rd = vecs[k].is_rd;
      CDB_valid = vecs[k].cdb_valid; CDB_name = vecs[k].cdb_name; CDB_val = vecs[k].cdb_val;
      rdy = vecs[k].en;
      #1;
      check($sformatf("vec%0d IS_name", k), 32'(IS_name), 32'(vecs[k].exp_name));
      check($sformatf("vec%0d IS_full", k), 32'(IS_full), 32'd0);
      tick();
      check($sformatf("vec%0d COM_valid", k), 32'(COM_valid), 32'(vecs[k].exp_cv));
      if (vecs[k].exp_cv) begin
        check($sformatf("vec%0d COM_name", k), 32'(COM_name), 32'(vecs[k].exp_cname));
        check($sformatf("vec%0d COM_rd", k), 32'(COM_rd), 32'(vecs[k].exp_crd));
        check($sformatf("vec%0d COM_val", k), COM_val, vecs[k].exp_cval);
      end
    end
    idle();

    // Fill to full, ignored allocation, then alloc+commit while full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      IS_valid = 1'b1; IS_rd = 5'(i + 1);
      #1;
      check("fill IS_name", 32'(IS_name), 32'(i));
      check("fill IS_full", 32'(IS_full), 32'd0);
      tick();
    end
    IS_valid = 1'b1; IS_rd = 5'd7;
    #1;
    check("full IS_full", 32'(IS_full), 32'd1);
    tick();
    IS_valid = 1'b0;
    check("ignored alloc IS_name", 32'(IS_name), 32'd0);
    check("ignored alloc IS_full", 32'(IS_full), 32'd1);
    CDB_valid = 1'b1; CDB_name = 4'd0; CDB_val = 32'h55;
    tick();
    CDB_valid = 1'b0;
    check("full no early commit", 32'(COM_valid), 32'd0);
    IS_valid = 1'b1; IS_rd = 5'd9;
    tick();
    IS_valid = 1'b0;
    REG_ord1 = 4'd0;
    #1;
    check("full swap COM_valid", 32'(COM_valid), 32'd1);
    check("full swap COM_name", 32'(COM_name), 32'd0);
    check("full swap COM_val", COM_val, 32'h55);
    check("full swap COM_rd", 32'(COM_rd), 32'd1);
    check("full swap IS_full", 32'(IS_full), 32'd1);
    check("full swap IS_name", 32'(IS_name), 32'd1);
    check("full swap new entry not ready", 32'(REG_rdy1), 32'd0);
    idle();

    // Flush discards same-cycle commit and CDB
    do_reset();
    alloc_n(5);
    CDB_valid = 1'b1; CDB_name = 4'd0; CDB_val = 32'hA;
    tick();
    CDB_name = 4'd3; CDB_val = 32'h3; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush IS_name", 32'(IS_name), 32'd0);
    check("flush IS_full", 32'(IS_full), 32'd0);
    check("flush COM_valid", 32'(COM_valid), 32'd0);
    CDB_name = 4'd3; CDB_val = 32'h77;
    tick();
    CDB_valid = 1'b0;
    REG_ord1 = 4'd3; REG_ord2 = 4'd0;
    #1;
    check("post-flush CDB rdy1", 32'(REG_rdy1), 32'd0);
    check("post-flush CDB val1", REG_val1, 32'd0);
    check("post-flush entry0 rdy2", 32'(REG_rdy2), 32'd0);
    check("post-flush COM_valid", 32'(COM_valid), 32'd0);
    tick();
    check("post-flush COM_valid2", 32'(COM_valid), 32'd0);
    idle();

    // Same-cycle lookup of a completing entry
    do_reset();
    alloc_n(6);
    REG_ord1 = 4'd5;
    CDB_valid = 1'b1; CDB_name = 4'd5; CDB_val = 32'h1234;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("bypass rdy1", 32'(REG_rdy1), 32'd1);
    check("bypass val1", REG_val1, 32'h1234);
`else
    check("no-bypass rdy1", 32'(REG_rdy1), 32'd0);
    check("no-bypass val1", REG_val1, 32'd0);
`endif
    tick();
    CDB_valid = 1'b0;
    #1;
    check("stored rdy1", 32'(REG_rdy1), 32'd1);
    check("stored val1", REG_val1, 32'h1234);
    check("head not ready COM_valid", 32'(COM_valid), 32'd0);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("async rst IS_name", 32'(IS_name), 32'd0);
    check("async rst rdy1", 32'(REG_rdy1), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the queue model
    do_reset();
    mq.delete();
    mtail = 0;
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom_range(0, 59) == 0);
      rdy       = ($urandom_range(0, 7) != 0);
      IS_valid  = ((n / 200) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      IS_rd     = 5'($urandom);
      CDB_valid = $urandom_range(0, 1) == 1;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        CDB_name = mq[$urandom_range(0, mq.size() - 1)].name;
      else
        CDB_name = 4'($urandom);
      CDB_val   = $urandom;
      REG_ord1  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].name : 4'($urandom);
      REG_ord2  = 4'($urandom);
      #1;
      check("rand IS_full", 32'(IS_full), 32'(mq.size() == 16));
      check("rand IS_name", 32'(IS_name), 32'(mtail));
      mlook(REG_ord1, er, ev);
      check("rand REG_rdy1", 32'(REG_rdy1), 32'(er));
      check("rand REG_val1", REG_val1, ev);
      mlook(REG_ord2, er, ev);
      check("rand REG_rdy2", 32'(REG_rdy2), 32'(er));
      check("rand REG_val2", REG_val2, ev);

      exp_cv = 1'b0;
      if (flush) begin
        mq.delete();
        mtail = 0;
      end else if (rdy) begin
        commit = (mq.size() > 0) && mq[0].ready;
        alloc  = IS_valid && ((mq.size() < 16) || commit);
        if (commit) begin
          exp_cv = 1'b1;
          exp_cname = mq[0].name;
          exp_crd = mq[0].rd;
          exp_cval = mq[0].val;
        end
        if (CDB_valid) begin
          foreach (mq[i]) begin
            if (mq[i].name == CDB_name) begin
              mq[i].ready = 1'b1;
              mq[i].val = CDB_val;
            end
          end
        end
        if (commit) void'(mq.pop_front());
        if (alloc) begin
          mq.push_back('{name: 4'(mtail), rd: IS_rd, ready: 1'b0, val: 32'h0});
          mtail = (mtail + 1) % 16;
        end
      end
      tick();
      check("rand COM_valid", 32'(COM_valid), 32'(exp_cv));
      if (exp_cv) begin
        check("rand COM_name", 32'(COM_name), 32'(exp_cname));
        check("rand COM_rd", 32'(COM_rd), 32'(exp_crd));
        check("rand COM_val", COM_val, exp_cval);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
